// File: rtl/ctech_lib_hs_toggle_tx_if.sv
`default_nettype none
// ============================================================================
// Module      : ctech_lib_hs_toggle_tx_if
// Description : Handshake bundle for the toggle req/ack CDC transmitter:
//               local producer side (in_*), far-domain side (tx_*) and status.
// Revision    : 1.0 - initial release
// ============================================================================
interface ctech_lib_hs_toggle_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             tx_req;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ack;
    logic             busy;
    logic             timeout_err;
    logic             protocol_err;

    // Environment side: drives the producer inputs and the far-end ack
    modport master (
        output in_valid, in_data, tx_ack,
        input  in_ready, tx_req, tx_data, busy, timeout_err, protocol_err
    );

    // Transmitter side
    modport slave (
        input  in_valid, in_data, tx_ack,
        output in_ready, tx_req, tx_data, busy, timeout_err, protocol_err
    );
endinterface
`default_nettype wire

// File: rtl/ctech_lib_hs_toggle_tx.sv
`default_nettype none
// ============================================================================
// Module      : ctech_lib_hs_toggle_tx
// Description : Source end of a two-phase toggle req/ack CDC handshake.
//               Captures a word, toggles tx_req, and waits until the
//               synchronized ack toggle matches tx_req before accepting again.
//               Flags ack-wait timeouts and spurious acks with sticky errors.
// Revision    : 1.0 - initial release
// ============================================================================
module ctech_lib_hs_toggle_tx #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    ctech_lib_hs_toggle_tx_if.slave  bus
);

    localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT);
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    typedef enum logic [0:0] {
        S_IDLE     = 1'b0,
        S_WAIT_ACK = 1'b1
    } state_t;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_ack_s;
    logic                   r_tx_req;
    logic [WIDTH-1:0]       r_tx_data;
    logic                   r_in_ready;
    logic                   r_busy;
    logic [15:0]            r_wait_cnt;
    logic [15:0]            w_cnt_inc;
    logic                   r_timeout_err;
    logic                   r_protocol_err;
    logic                   w_accept;
    logic                   w_ack_match;

    // Ack synchronizer: shift the asynchronous tx_ack through SYNC_STAGES flops
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], bus.tx_ack};
        end
    end

    assign w_ack_s     = r_sync[SYNC_STAGES-1];
    assign w_ack_match = (w_ack_s == r_tx_req);
    assign w_accept    = (r_state == S_IDLE) && r_in_ready && bus.in_valid;
    assign w_cnt_inc   = (r_wait_cnt == c_CNT_MAX) ? r_wait_cnt : (r_wait_cnt + 16'd1);

    // Next-state logic: accept moves to WAIT_ACK, matching ack returns to IDLE
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = S_WAIT_ACK;
                end
            end
            S_WAIT_ACK: begin
                if (w_ack_match) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Request toggle, held word and registered ready/busy; ready stays low
    // for the first cycle after reset so it rises on the first free edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tx_req   <= 1'b0;
            r_tx_data  <= '0;
            r_in_ready <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_accept) begin
                r_tx_req  <= ~r_tx_req;
                r_tx_data <= bus.in_data;
            end
            r_in_ready <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt == S_WAIT_ACK);
        end
    end

    // Saturating wait counter: cleared on accept, counts cycles spent waiting
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wait_cnt <= 16'd0;
        end else if (w_accept) begin
            r_wait_cnt <= 16'd0;
        end else if (r_state == S_WAIT_ACK) begin
            r_wait_cnt <= w_cnt_inc;
        end
    end

    // Sticky timeout flag: set when the counter reaches TIMEOUT; the transfer
    // keeps waiting and is never re-requested
    always_ff @(posedge clk) begin
        if (rst) begin
            r_timeout_err <= 1'b0;
        end else if ((c_TIMEOUT != 16'd0) && (r_state == S_WAIT_ACK) &&
                     (w_cnt_inc == c_TIMEOUT)) begin
            r_timeout_err <= 1'b1;
        end
    end

    // Sticky protocol flag: an ack toggle seen while nothing is outstanding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_protocol_err <= 1'b0;
        end else if ((r_state == S_IDLE) && !w_ack_match) begin
            r_protocol_err <= 1'b1;
        end
    end

    assign bus.in_ready     = r_in_ready;
    assign bus.tx_req       = r_tx_req;
    assign bus.tx_data      = r_tx_data;
    assign bus.busy         = r_busy;
    assign bus.timeout_err  = r_timeout_err;
    assign bus.protocol_err = r_protocol_err;

endmodule
`default_nettype wire

// File: tb/tb_ctech_lib_hs_toggle_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_ctech_lib_hs_toggle_tx
// Description : Scoreboard bench for ctech_lib_hs_toggle_tx. A far-end model
//               answers each request toggle with an ack toggle after a chosen
//               delay; accepted words are queued with their accept edge and a
//               monitor pops one per observed tx_req toggle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ctech_lib_hs_toggle_tx;

    localparam int WIDTH       = 8;
    localparam int SYNC_STAGES = 2;
    localparam int TIMEOUT     = 10;
    localparam int MIN_GAP     = SYNC_STAGES + 2;

    typedef struct {
        int               acc;
        logic [WIDTH-1:0] data;
    } exp_t;

    logic clk;
    logic rst;
    ctech_lib_hs_toggle_tx_if #(.WIDTH(WIDTH)) bus ();

    ctech_lib_hs_toggle_tx #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .TIMEOUT     (TIMEOUT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    exp_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    int   n_acc = 0;
    int   n_tog = 0;
    int   last_acc = 0;
    logic acc_now  = 1'b0;
    logic mon_en   = 1'b0;
    logic ack_hold = 1'b0;
    int   ack_dly  = 0;
    int   spur_req = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Record an acceptance about to happen on the coming edge, then advance
    task automatic tick();
        acc_now = 1'b0;
        if (bus.in_valid && bus.in_ready && !rst) begin
            sb.push_back('{acc: cyc + 1, data: bus.in_data});
            n_acc++;
            acc_now  = 1'b1;
            last_acc = cyc + 1;
        end
        @(negedge clk);
    endtask

    task automatic wait_ready(input int n);
        for (int i = 0; i < n && !bus.in_ready; i++) tick();
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
    endtask

    task automatic do_reset();
        mon_en       = 1'b0;
        bus.in_valid = 1'b0;
        rst          = 1'b1;
        repeat (3) tick();
        sb.delete();
        rst    = 1'b0;
        mon_en = 1'b1;
        tick();
    endtask

    // Far end: toggles tx_ack once per tx_req toggle after ack_dly cycles
    initial begin
        logic fe_seen;
        int   fe_cnt;
        int   spur_done;
        bus.tx_ack = 1'b0;
        fe_seen    = 1'b0;
        fe_cnt     = 0;
        spur_done  = 0;
        forever begin
            @(posedge clk);
            #2;
            if (rst) begin
                bus.tx_ack = 1'b0;
                fe_seen    = 1'b0;
                fe_cnt     = 0;
            end else if (spur_req != spur_done) begin
                bus.tx_ack = ~bus.tx_ack;
                spur_done  = spur_req;
            end else if ((bus.tx_req != fe_seen) && !ack_hold) begin
                if (fe_cnt >= ack_dly) begin
                    bus.tx_ack = ~bus.tx_ack;
                    fe_seen    = bus.tx_req;
                    fe_cnt     = 0;
                end else begin
                    fe_cnt++;
                end
            end
        end
    end

    // Monitor: each tx_req toggle must match the oldest queued acceptance
    initial begin
        logic             prev_req;
        logic [WIDTH-1:0] held;
        int               last_tog;
        exp_t             e;
        prev_req = 1'b0;
        held     = '0;
        last_tog = -1000;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev_req = bus.tx_req;
                held     = bus.tx_data;
                last_tog = -1000;
            end else begin
                if (bus.tx_req != prev_req) begin
                    n_tog++;
                    chk("toggle_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk("toggle_edge", 32'(cyc), 32'(e.acc));
                        chk("tx_data", 32'(bus.tx_data), 32'(e.data));
                    end
                    chk("toggle_gap_ok", 32'((cyc - last_tog) >= MIN_GAP), 32'd1);
                    last_tog = cyc;
                    held     = bus.tx_data;
                end else begin
                    if (sb.size() != 0) chk("no_missing_toggle", 32'(sb[0].acc > cyc), 32'd1);
                    if (bus.busy) chk("tx_data_hold", 32'(bus.tx_data), 32'(held));
                end
                prev_req = bus.tx_req;
            end
        end
    end

    initial begin
        int               k;
        int               acc_cyc [3];
        logic [WIDTH-1:0] words [3];
        int               acc0;
        int               tog0;
        words        = '{8'h01, 8'h02, 8'h03};
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;

        // Reset state
        repeat (3) tick();
        chk("rst_tx_req", 32'(bus.tx_req), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_timeout_err", 32'(bus.timeout_err), 32'd0);
        chk("rst_protocol_err", 32'(bus.protocol_err), 32'd0);
        rst    = 1'b0;
        mon_en = 1'b1;
        chk("ready_before_edge", 32'(bus.in_ready), 32'd0);
        tick();
        chk("ready_after_release", 32'(bus.in_ready), 32'd1);

        // Basic transfer with immediate ack
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        chk("basic_accept", 32'(acc_now), 32'd1);
        chk("basic_tx_req", 32'(bus.tx_req), 32'd1);
        chk("basic_tx_data", 32'(bus.tx_data), 32'hA5);
        chk("basic_busy", 32'(bus.busy), 32'd1);
        chk("basic_ready_low", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        tick();
        chk("basic_ready_e2", 32'(bus.in_ready), 32'd0);
        tick();
        chk("basic_ready_e3", 32'(bus.in_ready), 32'd1);
        chk("basic_busy_done", 32'(bus.busy), 32'd0);

        // Back-to-back transfers
        do_reset();
        k            = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = words[0];
        for (int t = 0; t < 30 && k < 3; t++) begin
            tick();
            if (acc_now) begin
                acc_cyc[k] = last_acc;
                chk("b2b_tx_req", 32'(bus.tx_req), 32'((k % 2) == 0));
                chk("b2b_tx_data", 32'(bus.tx_data), 32'(words[k]));
                k++;
                if (k < 3) bus.in_data = words[k];
                else       bus.in_valid = 1'b0;
            end
        end
        chk("b2b_count", 32'(k), 32'd3);
        chk("b2b_interval1", 32'(acc_cyc[1] - acc_cyc[0]), 32'(MIN_GAP));
        chk("b2b_interval2", 32'(acc_cyc[2] - acc_cyc[1]), 32'(MIN_GAP));
        wait_ready(10);

        // Timeout with ack withheld, then a late ack
        do_reset();
        ack_hold     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = WIDTH'($urandom);
        tick();
        chk("to_accept", 32'(acc_now), 32'd1);
        bus.in_valid = 1'b0;
        repeat (TIMEOUT - 1) tick();
        chk("to_not_yet", 32'(bus.timeout_err), 32'd0);
        tick();
        chk("to_set", 32'(bus.timeout_err), 32'd1);
        chk("to_busy", 32'(bus.busy), 32'd1);
        repeat (5) tick();
        chk("to_still_busy", 32'(bus.busy), 32'd1);
        chk("to_no_retoggle", 32'(bus.tx_req), 32'd1);
        ack_hold = 1'b0;
        wait_ready(8);
        chk("to_sticky", 32'(bus.timeout_err), 32'd1);
        chk("to_idle", 32'(bus.busy), 32'd0);

        // Spurious ack while idle
        do_reset();
        chk("spur_clear", 32'(bus.protocol_err), 32'd0);
        spur_req++;
        repeat (3) tick();
        chk("spur_not_yet", 32'(bus.protocol_err), 32'd0);
        tick();
        chk("spur_set", 32'(bus.protocol_err), 32'd1);
        chk("spur_ready", 32'(bus.in_ready), 32'd1);
        chk("spur_idle", 32'(bus.busy), 32'd0);
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        chk("spur_next_accept", 32'(acc_now), 32'd1);
        bus.in_valid = 1'b0;
        wait_ready(10);

        // Reset pulse while waiting for ack
        do_reset();
        ack_hold     = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        tick();
        bus.in_valid = 1'b0;
        tick();
        chk("rw_req_before", 32'(bus.tx_req), 32'd1);
        chk("rw_busy_before", 32'(bus.busy), 32'd1);
        mon_en = 1'b0;
        rst    = 1'b1;
        tick();
        chk("rw_tx_req", 32'(bus.tx_req), 32'd0);
        chk("rw_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_ready_low", 32'(bus.in_ready), 32'd0);
        rst = 1'b0;
        sb.delete();
        mon_en = 1'b1;
        tick();
        chk("rw_ready_high", 32'(bus.in_ready), 32'd1);
        ack_hold = 1'b0;

        // in_valid held high with in_data changing every cycle
        do_reset();
        ack_dly      = 2;
        acc0         = n_acc;
        tog0         = n_tog;
        bus.in_valid = 1'b1;
        for (int t = 0; t < 40; t++) begin
            bus.in_data = WIDTH'($urandom);
            tick();
        end
        bus.in_valid = 1'b0;
        wait_ready(12);
        repeat (2) tick();
        chk("held_one_toggle_each", 32'(n_tog - tog0), 32'(n_acc - acc0));
        chk("held_enough_xfers", 32'((n_acc - acc0) >= 5), 32'd1);

        // Randomized traffic with random ack delays
        do_reset();
        acc0 = n_acc;
        tog0 = n_tog;
        for (int t = 0; t < 400; t++) begin
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.in_data  = WIDTH'($urandom);
            ack_dly      = int'($urandom_range(0, 4));
            tick();
        end
        bus.in_valid = 1'b0;
        wait_ready(20);
        repeat (3) tick();
        chk("rand_toggles", 32'(n_tog - tog0), 32'(n_acc - acc0));
        chk("rand_sb_empty", 32'(sb.size()), 32'd0);
        chk("rand_no_timeout", 32'(bus.timeout_err), 32'd0);
        chk("rand_no_protocol", 32'(bus.protocol_err), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctech_lib_hs_toggle_tx.md
CTECH_LIB_HS_TOGGLE_TX -- requirements
Module: ctech_lib_hs_toggle_tx

Interface
REQ-001 The block SHALL be the transmit (source) end of a two-phase toggle req/ack CDC handshake, synchronizing the returning ack internally.
REQ-002 Parameter WIDTH, default 8: width of the transferred data word, 1..256.
REQ-003 Parameter SYNC_STAGES, default 2: number of flops in the ack synchronizer chain, 2..4.
REQ-004 Parameter TIMEOUT, default 0: number of cycles in WAIT_ACK before timeout_err asserts; 0 disables the timeout, legal range 0..65535.
REQ-005 Port clk, input, 1 bit: the single clock; every flop is on its rising edge.
REQ-006 Port rst, input, 1 bit: reset; synchronous and active-high.
REQ-007 Port in_valid, input, 1 bit: the local producer offers in_data.
REQ-008 Port in_data, input, WIDTH bits: word to transfer.
REQ-009 Port in_ready, output, 1 bit: registered; high only in IDLE.
REQ-010 Port tx_req, output, 1 bit: request toggle toward the far domain, driven straight from a flop.
REQ-011 Port tx_data, output, WIDTH bits: held word, driven straight from a flop.
REQ-012 Port tx_ack, input, 1 bit: ack toggle from the far domain, asynchronous to clk.
REQ-013 Port busy, output, 1 bit: high in WAIT_ACK.
REQ-014 Port timeout_err, output, 1 bit: sticky; cleared only by rst.
REQ-015 Port protocol_err, output, 1 bit: sticky; cleared only by rst.

Function
REQ-016 There SHALL be two states, IDLE and WAIT_ACK; ack_s is the last stage of the SYNC_STAGES-deep synchronizer on tx_ack.
REQ-017 In IDLE, when in_valid && in_ready, the next edge SHALL:
  - load tx_data <= in_data;
  - invert tx_req;
  - enter WAIT_ACK;
  - drop in_ready and raise busy.
REQ-018 tx_data SHALL NOT change while in WAIT_ACK, and SHALL change only on an accepted transfer.
REQ-019 In WAIT_ACK, when ack_s == tx_req, the next edge SHALL enter IDLE, raise in_ready and drop busy.
REQ-020 Because in_ready is registered, an in_valid presented on the edge where ack_s matches SHALL NOT be accepted; it is accepted one cycle later.
REQ-021 The minimum accept-to-accept interval SHALL be SYNC_STAGES + 2 cycles, assuming the far end acks with zero delay.
REQ-022 A 16-bit wait counter SHALL behave as follows:
  - clear on entry to WAIT_ACK;
  - increment each cycle in WAIT_ACK;
  - saturate at 65535.
REQ-023 When TIMEOUT != 0 and the counter equals TIMEOUT, timeout_err SHALL set; the FSM SHALL keep waiting and SHALL NOT abort or re-toggle.
REQ-024 In IDLE, if ack_s != tx_req, protocol_err SHALL set; the block SHALL ignore the spurious ack and stay IDLE with in_ready high.
REQ-025 in_valid SHALL be ignored outside IDLE; in_data is not sampled then.
REQ-026 tx_req SHALL toggle at most once per transfer and never twice in consecutive cycles.

Reset
REQ-027 While rst is high, at the next edge the block SHALL set:
  - state = IDLE;
  - tx_req, tx_data, all synchronizer flops and the wait counter = 0;
  - in_ready, busy, timeout_err and protocol_err = 0.
REQ-028 in_ready SHALL rise on the first edge after rst deasserts.
REQ-029 rst asserted in WAIT_ACK SHALL abandon the transfer with no completion indication; the far end is reset by the system in the same reset event.
REQ-030 An ack toggle arriving within SYNC_STAGES cycles after reset release SHALL be flagged as protocol_err.

Verification
REQ-031 The bench SHALL cover these directed scenarios:
  - Basic transfer, WIDTH=8, SYNC_STAGES=2: in_data=0xA5 accepted at edge 0 -> tx_req 0->1 and tx_data=0xA5 at edge 1; tx_ack toggles at edge 1 -> in_ready high at edge 4.
  - Back-to-back transfers 0x01, 0x02, 0x03 with immediate ack -> tx_req sequence 1,0,1; transfers accepted exactly 4 cycles apart; tx_data stable while busy.
  - Timeout, TIMEOUT=10, ack withheld -> timeout_err rises 10 cycles after entering WAIT_ACK; busy stays high; a late ack then returns the block to IDLE with timeout_err still high.
  - Spurious ack toggle while IDLE -> protocol_err set within SYNC_STAGES+1 cycles; the next transfer still completes normally.
  - rst pulsed 1 cycle in WAIT_ACK with tx_req=1 -> next cycle tx_req=0, tx_data=0, state IDLE; in_ready=1 one cycle after rst falls.
  - in_valid held high during WAIT_ACK while in_data changes -> tx_data keeps its first value; exactly one toggle per transfer.
